// File: rtl/mtm_alu_pkg.sv
// -----------------------------------------------------------------------------
// mtm_alu_pkg
// Shared types, frame constants and helper functions for the mtm_Alu serial
// front end (frame receiver and packet deserializer).
// -----------------------------------------------------------------------------
package mtm_alu_pkg;

  // ALU opcodes carried in the CMD frame.
  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;

  // Frame type bit, the first bit after the start bit.
  typedef enum logic {
    DATA = 1'b0,
    CMD  = 1'b1
  } packet_t;

  // Error code presented with out_valid: {ERR_DATA, ERR_CRC, ERR_OP}.
  typedef enum logic [2:0] {
    ERR_NONE = 3'b000,
    ERR_DATA = 3'b100,
    ERR_CRC  = 3'b010,
    ERR_OP   = 3'b001
  } processing_error_t;

  // Bit-level receiver states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_STOP = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Type bit plus 8 data bits are shifted between start and stop.
  localparam int unsigned FRAME_PAYLOAD_BITS = 9;

  // Number of DATA frames in a well-formed packet.
  localparam int unsigned PKT_DATA_BYTES = 8;

  // Serial CRC4, polynomial x^4 + x + 1, data bit 67 enters first.
  function automatic logic [3:0] crc4_d68(input logic [67:0] data,
                                          input logic [3:0]  crc_init);
    logic [3:0] c;
    logic       fb;
    c = crc_init;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Only four of the eight opcode encodings are implemented by the core.
  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    case (op)
      AND, OR, ADD, SUB: ok = 1'b1;
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// -----------------------------------------------------------------------------
// mtm_alu_frame_rx
// Bit-level receiver for 11-bit sin frames: start(0), type, d[7:0], stop(1),
// MSB first, one bit per clock.
//
// Ports:
//   clk            system clock, sin sampled on posedge
//   rst_n          asynchronous active-low reset
//   i_sin          serial input, idles high
//   o_frame_valid  1-cycle pulse: frame with a good stop bit received
//   o_frame_type   type bit of the last frame (packet_t encoding)
//   o_frame_byte   data byte of the last frame
//   o_frame_err    1-cycle pulse: stop bit sampled low (frame dropped)
//   o_idle         receiver waiting for a start bit
//                  (present only with MTM_ALU_DESER_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sin,
  output logic       o_frame_valid,
  output logic       o_frame_type,
  output logic [7:0] o_frame_byte,
`ifdef MTM_ALU_DESER_TIMEOUT_EN
  output logic       o_idle,
`endif
  output logic       o_frame_err
);

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_bit_cnt;
  logic [8:0] r_shift;
  logic       r_frame_valid;
  logic       r_frame_err;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_sin == START_BIT) w_state_nxt = S_RX;
      S_RX:    if (r_bit_cnt == 4'(FRAME_PAYLOAD_BITS - 1)) w_state_nxt = S_STOP;
      S_STOP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register and result pulses. The shift register only moves in RX,
  // so type/byte stay stable through the pulse cycle even when the next
  // start bit follows the stop bit directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt     <= 4'd0;
      r_shift       <= 9'd0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: r_bit_cnt <= 4'd0;
        S_RX: begin
          r_shift   <= {r_shift[7:0], i_sin};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        S_STOP: begin
          if (i_sin == STOP_BIT) r_frame_valid <= 1'b1;
          else                   r_frame_err   <= 1'b1;
        end
        default: r_bit_cnt <= 4'd0;
      endcase
    end
  end

  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_frame_type  = r_shift[8];
  assign o_frame_byte  = r_shift[7:0];
`ifdef MTM_ALU_DESER_TIMEOUT_EN
  assign o_idle        = (r_state == S_IDLE);
`endif

endmodule

// File: rtl/mtm_alu_deserializer.sv
// -----------------------------------------------------------------------------
// mtm_alu_deserializer
// Input front end of the mtm_Alu. Collects 8 DATA frames (B[31:24] first,
// A[7:0] last) and one CMD frame {0, op[2:0], crc[3:0]}, then presents one
// operation or one error code per command.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sin        serial input, idles high
//   out_valid  1-cycle pulse, the cycle after the CMD stop bit
//   out_a      operand A (held until next out_valid)
//   out_b      operand B (held until next out_valid)
//   out_op     opcode from the CMD frame
//   out_err    {ERR_DATA, ERR_CRC, ERR_OP}, one-hot or 000
//
// Build option:
//   MTM_ALU_DESER_TIMEOUT_EN  when defined, a partial packet left idle for
//                             TIMEOUT_CYCLES cycles is reported as ERR_DATA.
// -----------------------------------------------------------------------------
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err
);

  logic              w_frame_valid;
  logic              w_frame_type;
  logic [7:0]        w_frame_byte;
  logic              w_frame_err;

  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [3:0]        r_byte_cnt;
  logic              r_bad_pkt;

  logic              r_valid;
  logic [31:0]       r_out_a;
  logic [31:0]       r_out_b;
  logic [2:0]        r_out_op;
  logic [2:0]        r_out_err;

  logic              w_is_data;
  logic              w_is_cmd;
  logic [2:0]        w_cmd_op;
  logic [3:0]        w_cmd_crc;
  logic [1:0]        w_lane;
  processing_error_t w_cmd_err;
  logic              w_timeout;

`ifdef MTM_ALU_DESER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 256;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            w_rx_idle;
  logic            w_to_arm;
  logic [TO_W-1:0] r_to_cnt;
`endif

  mtm_alu_frame_rx u_frame_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sin         (sin),
    .o_frame_valid (w_frame_valid),
    .o_frame_type  (w_frame_type),
    .o_frame_byte  (w_frame_byte),
`ifdef MTM_ALU_DESER_TIMEOUT_EN
    .o_idle        (w_rx_idle),
`endif
    .o_frame_err   (w_frame_err)
  );

  assign w_is_data = w_frame_valid && (w_frame_type == DATA);
  assign w_is_cmd  = w_frame_valid && (w_frame_type == CMD);
  assign w_cmd_op  = w_frame_byte[6:4];
  assign w_cmd_crc = w_frame_byte[3:0];

  // Byte 0 of each operand is its most significant byte.
  assign w_lane    = 2'd3 - r_byte_cnt[1:0];

  // Fixed error priority: framing/count, then CRC, then opcode.
  always_comb begin
    w_cmd_err = ERR_NONE;
    if ((r_byte_cnt != 4'(PKT_DATA_BYTES)) || r_bad_pkt)
      w_cmd_err = ERR_DATA;
    else if (w_cmd_crc != crc4_d68({r_b, r_a, 1'b1, w_cmd_op}, 4'h0))
      w_cmd_err = ERR_CRC;
    else if (!op_is_valid(w_cmd_op))
      w_cmd_err = ERR_OP;
  end

`ifdef MTM_ALU_DESER_TIMEOUT_EN
  // Counts consecutive idle cycles while a packet is partially received;
  // any frame activity restarts the count.
  assign w_to_arm  = w_rx_idle && (r_byte_cnt != 4'd0) &&
                     !w_frame_valid && !w_frame_err;
  assign w_timeout = w_to_arm && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_to_cnt <= '0;
    else if (w_to_arm && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
    else                            r_to_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: operand storage is reset like every other register because the
  // block must come out of reset with all outputs and packet state at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_byte_cnt <= 4'd0;
      r_bad_pkt  <= 1'b0;
      r_valid    <= 1'b0;
      r_out_a    <= 32'd0;
      r_out_b    <= 32'd0;
      r_out_op   <= 3'd0;
      r_out_err  <= 3'd0;
    end else begin
      r_valid <= 1'b0;

      if (w_frame_err) r_bad_pkt <= 1'b1;

      if (w_is_data) begin
        if (r_byte_cnt < 4'(PKT_DATA_BYTES)) begin
          if (r_byte_cnt[2]) r_a[{w_lane, 3'b000} +: 8] <= w_frame_byte;
          else               r_b[{w_lane, 3'b000} +: 8] <= w_frame_byte;
        end
        // Saturating at 9 still distinguishes "too many" from "exactly 8".
        if (r_byte_cnt != 4'(PKT_DATA_BYTES + 1)) r_byte_cnt <= r_byte_cnt + 4'd1;
      end

      if (w_is_cmd) begin
        r_valid    <= 1'b1;
        r_out_a    <= r_a;
        r_out_b    <= r_b;
        r_out_op   <= w_cmd_op;
        r_out_err  <= w_cmd_err;
        r_byte_cnt <= 4'd0;
        r_bad_pkt  <= 1'b0;
      end else if (w_timeout) begin
        r_valid    <= 1'b1;
        r_out_a    <= r_a;
        r_out_b    <= r_b;
        r_out_err  <= ERR_DATA;
        r_byte_cnt <= 4'd0;
        r_bad_pkt  <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_op    = r_out_op;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// -----------------------------------------------------------------------------
// tb_mtm_alu_deserializer
// Directed packets on sin; each CMD pushes its expected response into a
// scoreboard queue, and an independent monitor pops and compares whenever
// out_valid is seen.
// -----------------------------------------------------------------------------
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
    bit          chk_ab;
    bit          chk_op;
    int          exp_cyc;   // -1: latency not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC as polynomial division: remainder of M(x)*x^4 mod x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  // Monitor: every out_valid cycle must match the oldest expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: out_valid=1 with err=%b, required no response", out_err);
      end else begin
        m_e = sb.pop_front();
        check("out_err", 32'(out_err), 32'(m_e.err));
        if (m_e.chk_op) check("out_op", 32'(out_op), 32'(m_e.op));
        if (m_e.chk_ab) begin
          check("out_a", out_a, m_e.a);
          check("out_b", out_b, m_e.b);
        end
        if (m_e.exp_cyc >= 0) check("latency", 32'(cyc), 32'(m_e.exp_cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] by, input logic stop,
                            input bit push, input exp_t e);
    logic [10:0] f;
    f = {1'b0, typ, by, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = f[i];
      if (i == 0 && push) begin
        // stop sampled on the next posedge, out_valid set on the one after
        e.exp_cyc = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  // n DATA frames; frame index bad_idx (if >= 0) gets a low stop bit.
  task automatic send_data(input logic [31:0] b, input logic [31:0] a,
                           input int n, input int bad_idx);
    logic [63:0] ba;
    logic [7:0]  by;
    exp_t        dummy;
    int          j;
    ba = {b, a};
    j  = 0;
    dummy = '{a: 0, b: 0, op: 0, err: 0, chk_ab: 0, chk_op: 0, exp_cyc: -1};
    for (int i = 0; i < n; i++) begin
      by = (j < 8) ? ba[63 - 8*j -: 8] : 8'hA5;
      if (i == bad_idx) begin
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, dummy);
      end else begin
        send_frame(1'b0, by, 1'b1, 1'b0, dummy);
        j++;
      end
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc, input logic stop,
                          input bit push, input logic [2:0] err, input bit chk_ab,
                          input logic [31:0] b, input logic [31:0] a);
    exp_t e;
    e = '{a: a, b: b, op: op, err: err, chk_ab: chk_ab, chk_op: 1, exp_cyc: -1};
    send_frame(1'b1, {1'b0, op, crc}, stop, push, e);
  endtask

  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [3:0] crc_x, input int n, input int bad_idx,
                          input logic [2:0] err, input bit chk_ab);
    send_data(b, a, n, bad_idx);
    send_cmd(op, ref_crc({b, a, 1'b1, op}) ^ crc_x, 1'b1, 1'b1, err, chk_ab, b, a);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_a"},     out_a,          32'd0);
    check({tag, "_b"},     out_b,          32'd0);
    check({tag, "_op"},    32'(out_op),    32'd0);
    check({tag, "_err"},   32'(out_err),   32'd0);
  endtask

  initial begin
    exp_t dummy;
    dummy = '{a: 0, b: 0, op: 0, err: 0, chk_ab: 0, chk_op: 0, exp_cyc: -1};
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Clean ADD, then inverted CRC, then an unsupported opcode.
    send_pkt(32'h0000_0002, 32'h0000_0001, 3'b100, 4'h0, 8, -1, 3'b000, 1'b1);
    idle(3);
    send_pkt(32'h0000_0002, 32'h0000_0001, 3'b100, 4'hF, 8, -1, 3'b010, 1'b1);
    idle(3);
    send_pkt(32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 4'h0, 8, -1, 3'b001, 1'b1);
    idle(3);

    // Byte count errors: too few, too many.
    send_pkt(32'h1111_2222, 32'h3333_4444, 3'b100, 4'h0, 3, -1, 3'b100, 1'b0);
    idle(3);
    send_pkt(32'h1111_2222, 32'h3333_4444, 3'b100, 4'h0, 10, -1, 3'b100, 1'b0);
    idle(3);

    // Framing error in frame 5, still exactly 8 good DATA frames.
    send_pkt(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b001, 4'h0, 9, 4, 3'b100, 1'b0);
    // Clean packets, back-to-back with the previous one.
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0, 8, -1, 3'b000, 1'b1);
    idle(5);
    send_pkt(32'hA5A5_5A5A, 32'h0F0F_F0F0, 3'b000, 4'h0, 8, -1, 3'b000, 1'b1);
    send_pkt(32'h8000_0001, 32'h7FFF_FFFE, 3'b001, 4'h0, 8, -1, 3'b000, 1'b1);
    idle(2);

    // CMD with a bad stop bit: no response; the next CMD reports ERR_DATA.
    send_data(32'h0102_0304, 32'h0506_0708, 8, -1);
    send_cmd(3'b100, ref_crc({32'h0102_0304, 32'h0506_0708, 1'b1, 3'b100}),
             1'b0, 1'b0, 3'b000, 1'b0, 0, 0);
    idle(4);
    send_cmd(3'b100, ref_crc({32'h0102_0304, 32'h0506_0708, 1'b1, 3'b100}),
             1'b1, 1'b1, 3'b100, 1'b0, 0, 0);
    idle(4);

    // Reset asserted during bit 6 of the CMD frame.
    send_data(32'h0A0B_0C0D, 32'h0E0F_1011, 8, -1);
    begin
      logic [10:0] f;
      f = {1'b0, 1'b1, 1'b0, 3'b100, 4'h5, 1'b1};
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        sin = f[10 - k];
      end
      @(negedge clk);
      rst_n = 1'b0;
      sin   = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("postreset");

    // Fresh packet immediately after reset release, no idle gaps.
    send_pkt(32'h0000_0064, 32'h0000_0032, 3'b101, 4'h0, 8, -1, 3'b000, 1'b1);
    idle(3);

`ifdef MTM_ALU_DESER_TIMEOUT_EN
    begin
      exp_t e;
      send_data(32'h5555_6666, 32'h7777_8888, 2, -1);
      e = '{a: 0, b: 0, op: 0, err: 3'b100, chk_ab: 0, chk_op: 0, exp_cyc: -1};
      sb.push_back(e);
      idle(300);
    end
`else
    // Without a timeout a partial packet is reported at the next CMD.
    send_data(32'h5555_6666, 32'h7777_8888, 2, -1);
    idle(300);
    send_cmd(3'b000, 4'h0, 1'b1, 1'b1, 3'b100, 1'b0, 0, 0);
    idle(3);
`endif

    send_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 4'h0, 8, -1, 3'b000, 1'b1);

    // Bounded drain of outstanding expectations.
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    idle(5);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
